elbeth_bridge_mem_subsys: RTL and testbench

- Processor-facing memory subsystem for the ELBETH CPU.
- A bridge translates the instruction port (imem_*) and the data port (dmem_*) into two internal word-addressed ports, A and B, on a true dual-port 32-bit synchronous RAM.
- The bridge flags misaligned and out-of-range accesses as exceptions; those accesses never reach the RAM.
- Instruction fetch uses port A; data load/store uses port B. Both operate in parallel every cycle.

---
 rtl/elbeth_bridge_mem_subsys.sv | 142 ++++++++++++++
 tb/tb_elbeth_bridge_mem_subsys.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/elbeth_bridge_mem_subsys.sv
// ELBETH memory subsystem: address bridge in front of a dual-port word RAM.
// Define ELBETH_MEM_CLEAR_EN to make reset clear every RAM word.
module elbeth_bridge_mem_subsys #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       imem_addr,
   output logic [DATA_W-1:0] imem_in_data,
   output logic              imem_ready,
   output logic              imem_except,
   output logic [3:0]        imem_except_src,
   input  logic              dmem_en,
   input  logic [31:0]       dmem_addr,
   input  logic [DATA_W-1:0] dmem_out_data,
   input  logic [3:0]        dmem_rw,
   output logic [DATA_W-1:0] dmem_in_data,
   output logic              dmem_ready,
   output logic              dmem_except,
   output logic [3:0]        dmem_except_src
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef struct packed {
      logic              en;
      logic [ADDR_W-1:0] addr;
      logic [3:0]        mask;
      logic [DATA_W-1:0] wdata;
   } port_req_t;

   function automatic logic [3:0] exc_src(input logic [31:0] a);
      exc_src = {2'b00, |a[31:ADDR_W+2], |a[1:0]};
   endfunction

   function automatic logic [DATA_W-1:0] merge(
      input logic [DATA_W-1:0] old,
      input logic [DATA_W-1:0] wdata,
      input logic [3:0]        mask
   );
      logic [DATA_W-1:0] w;
      w = old;
      for (int l = 0; l < 4; l++) begin
         if (mask[l]) w[8*l +: 8] = wdata[8*l +: 8];
      end
      return w;
   endfunction

   logic [DATA_W-1:0] mem [DEPTH];

`ifdef ELBETH_MEM_CLEAR_EN
   // Per-word valid bits stand in for a bulk clear: an invalid word reads 0.
   logic [DEPTH-1:0] vld;
`endif

   port_req_t         req_a;
   port_req_t         req_b;
   logic [DATA_W-1:0] a_old;
   logic [DATA_W-1:0] b_old;
   logic [DATA_W-1:0] a_new;
   logic [DATA_W-1:0] b_new;
   logic              same_word;
   logic              a_wr;
   logic              b_wr;
   logic              a_ready;
   logic              b_ready;
   logic [DATA_W-1:0] a_data;
   logic [DATA_W-1:0] b_data;

   always_comb begin
      imem_except_src = exc_src(imem_addr);
      imem_except     = |imem_except_src;
      dmem_except_src = dmem_en ? exc_src(dmem_addr) : 4'b0000;
      dmem_except     = |dmem_except_src;
   end

   always_comb begin
      req_a.en    = !imem_except;
      req_a.addr  = imem_addr[ADDR_W+1:2];
      req_a.mask  = 4'b0000;
      req_a.wdata = '0;
      req_b.en    = dmem_en && !dmem_except;
      req_b.addr  = dmem_addr[ADDR_W+1:2];
      req_b.mask  = dmem_rw;
      req_b.wdata = dmem_out_data;
   end

   always_comb begin
`ifdef ELBETH_MEM_CLEAR_EN
      a_old = vld[req_a.addr] ? mem[req_a.addr] : '0;
      b_old = vld[req_b.addr] ? mem[req_b.addr] : '0;
`else
      a_old = mem[req_a.addr];
      b_old = mem[req_b.addr];
`endif
      same_word = req_a.en && req_b.en && (req_a.addr == req_b.addr);
      a_new     = merge(a_old, req_a.wdata, req_a.mask);
      // On a shared word B merges over A, so B owns overlapping lanes.
      b_new     = merge(same_word ? a_new : b_old, req_b.wdata, req_b.mask);
      b_wr      = req_b.en && |req_b.mask;
      a_wr      = req_a.en && |req_a.mask && !(same_word && b_wr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         if (a_wr) mem[req_a.addr] <= a_new;
         if (b_wr) mem[req_b.addr] <= b_new;
      end
   end

`ifdef ELBETH_MEM_CLEAR_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld <= '0;
      end else begin
         if (a_wr) vld[req_a.addr] <= 1'b1;
         if (b_wr) vld[req_b.addr] <= 1'b1;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_ready <= 1'b0;
         a_data  <= '0;
         b_ready <= 1'b0;
         b_data  <= '0;
      end else begin
         a_ready <= req_a.en;
         b_ready <= req_b.en;
         if (req_a.en) a_data <= a_new;
         if (req_b.en) b_data <= b_new;
      end
   end

   assign imem_ready   = a_ready;
   assign imem_in_data = a_data;
   assign dmem_ready   = b_ready;
   assign dmem_in_data = b_data;

endmodule

// File: tb/tb_elbeth_bridge_mem_subsys.sv
// Randomized bench for elbeth_bridge_mem_subsys with a word-array model.
// Directed literal checks pin the model; a negedge process compares every cycle.
module tb_elbeth_bridge_mem_subsys;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] imem_addr = 32'h1000;
   logic [31:0] imem_in_data;
   logic        imem_ready;
   logic        imem_except;
   logic [3:0]  imem_except_src;
   logic        dmem_en = 1'b0;
   logic [31:0] dmem_addr = 32'h0;
   logic [31:0] dmem_out_data = 32'h0;
   logic [3:0]  dmem_rw = 4'h0;
   logic [31:0] dmem_in_data;
   logic        dmem_ready;
   logic        dmem_except;
   logic [3:0]  dmem_except_src;

   int passed = 0;
   int total  = 0;
   bit run    = 0;

   elbeth_bridge_mem_subsys dut (
      .clk(clk), .rst(rst),
      .imem_addr(imem_addr), .imem_in_data(imem_in_data),
      .imem_ready(imem_ready), .imem_except(imem_except),
      .imem_except_src(imem_except_src),
      .dmem_en(dmem_en), .dmem_addr(dmem_addr),
      .dmem_out_data(dmem_out_data), .dmem_rw(dmem_rw),
      .dmem_in_data(dmem_in_data), .dmem_ready(dmem_ready),
      .dmem_except(dmem_except), .dmem_except_src(dmem_except_src)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Model: 256-word array, byte space is 1024 bytes.
   logic [31:0] m [256];
   logic [31:0] e_id = 0, e_dd = 0;
   logic        e_ir = 0, e_dr = 0;

   function automatic logic [3:0] exc(input logic [31:0] a, input bit en);
      logic [3:0] s;
      s = 4'b0000;
      if (en && (a % 4) != 0) s = s | 4'b0001;
      if (en && a >= 32'd1024) s = s | 4'b0010;
      return s;
   endfunction

   always @(posedge clk or negedge rst) begin
      logic [31:0] w;
      int ia, da;
      if (!rst) begin
         e_ir = 0; e_dr = 0; e_id = 0; e_dd = 0;
`ifdef ELBETH_MEM_CLEAR_EN
         for (int i = 0; i < 256; i++) m[i] = 32'h0;
`endif
      end else begin
         ia = int'(imem_addr / 4);
         da = int'(dmem_addr / 4);
         if (exc(imem_addr, 1) == 0) begin
            e_id = m[ia]; e_ir = 1;
         end else e_ir = 0;
         if (exc(dmem_addr, dmem_en) == 0 && dmem_en) begin
            w = m[da];
            for (int l = 0; l < 4; l++)
               if (dmem_rw[l]) w[8*l +: 8] = dmem_out_data[8*l +: 8];
            m[da] = w; e_dd = w; e_dr = 1;
         end else e_dr = 0;
      end
   end

   always @(negedge clk) begin
      logic [3:0] si, sd;
      if (run) begin
         si = exc(imem_addr, 1);
         sd = exc(dmem_addr, dmem_en);
         chk("imem_except_src", {28'h0, imem_except_src}, {28'h0, si});
         chk("imem_except", {31'h0, imem_except}, {31'h0, si != 0});
         chk("dmem_except_src", {28'h0, dmem_except_src}, {28'h0, sd});
         chk("dmem_except", {31'h0, dmem_except}, {31'h0, sd != 0});
         chk("imem_ready", {31'h0, imem_ready}, {31'h0, e_ir});
         chk("dmem_ready", {31'h0, dmem_ready}, {31'h0, e_dr});
         chk("imem_in_data", imem_in_data, e_id);
         chk("dmem_in_data", dmem_in_data, e_dd);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic dwr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] rw);
      dmem_en = 1; dmem_addr = a; dmem_out_data = d; dmem_rw = rw;
      step();
   endtask

   function automatic logic [31:0] raddr();
      case ($urandom_range(0, 9))
         0: return ($urandom_range(0, 255) * 4) + $urandom_range(1, 3);
         1: return $urandom | 32'h400;
         default: return $urandom_range(0, 255) * 4;
      endcase
   endfunction

   initial begin
      logic [31:0] exp_11c;
      repeat (3) @(posedge clk);
      #3 rst = 1;
      step();
      run = 1;
      chk("reset imem_ready", {31'h0, imem_ready}, 32'h0);
      chk("reset dmem_in_data", dmem_in_data, 32'h0);
      for (int i = 0; i < 256; i++) dwr(i * 4, $urandom, 4'hF);
      dmem_en = 0;

      imem_addr = 32'h3;
      #1;
      chk("misaligned fetch except", {31'h0, imem_except}, 32'h1);
      chk("misaligned fetch src", {28'h0, imem_except_src}, 32'h1);
      step();
      chk("misaligned fetch ready", {31'h0, imem_ready}, 32'h0);

      dwr(32'h0, 32'h11223344, 4'hF);
      dwr(32'h8, 32'hCAFEF00D, 4'hF);
      imem_addr = 32'h0;
      dwr(32'h8, 32'h0, 4'h0);
      chk("parallel imem data", imem_in_data, 32'h11223344);
      chk("parallel dmem data", dmem_in_data, 32'hCAFEF00D);
      chk("parallel imem ready", {31'h0, imem_ready}, 32'h1);
      chk("parallel dmem ready", {31'h0, dmem_ready}, 32'h1);
      chk("parallel excepts", {30'h0, imem_except, dmem_except}, 32'h0);

      dwr(32'h11C, 32'hFFFFFFBA, 4'hF);
      chk("store dmem ready", {31'h0, dmem_ready}, 32'h1);
      chk("store dmem data", dmem_in_data, 32'hFFFFFFBA);
      imem_addr = 32'h11C;
      dmem_en = 0;
      step();
      chk("fetch after store", imem_in_data, 32'hFFFFFFBA);

      dwr(32'h10, 32'h0, 4'hF);
      dwr(32'h10, 32'hAABBCCDD, 4'b0010);
      chk("byte store merged", dmem_in_data, 32'h0000CC00);
      dwr(32'h10, 32'h0, 4'h0);
      chk("byte store readback", dmem_in_data, 32'h0000CC00);

      dmem_en = 1; dmem_addr = 32'h400; dmem_out_data = 32'hDEADBEEF;
      dmem_rw = 4'hF;
      #1;
      chk("oor except", {31'h0, dmem_except}, 32'h1);
      chk("oor src", {28'h0, dmem_except_src}, 32'h2);
      step();
      chk("oor ready", {31'h0, dmem_ready}, 32'h0);
      dmem_addr = 32'h401;
      #1;
      chk("oor misaligned src", {28'h0, dmem_except_src}, 32'h3);
      step();
      dwr(32'h0, 32'h0, 4'h0);
      chk("oor ram unchanged", dmem_in_data, 32'h11223344);

      imem_addr = 32'h11C;
      dwr(32'h11C, 32'h0, 4'h0);
      #2 rst = 0;
      #1;
      chk("async rst imem_ready", {31'h0, imem_ready}, 32'h0);
      chk("async rst dmem_ready", {31'h0, dmem_ready}, 32'h0);
      chk("async rst imem data", imem_in_data, 32'h0);
      chk("async rst dmem data", dmem_in_data, 32'h0);
      @(posedge clk);
      #3 rst = 1;
      step();
`ifdef ELBETH_MEM_CLEAR_EN
      exp_11c = 32'h0;
`else
      exp_11c = 32'hFFFFFFBA;
`endif
      chk("post rst dmem read", dmem_in_data, exp_11c);
      chk("post rst imem read", imem_in_data, exp_11c);
      chk("post rst ready", {30'h0, imem_ready, dmem_ready}, 32'h3);

      for (int n = 0; n < 3000; n++) begin
         imem_addr     = raddr();
         dmem_en       = ($urandom_range(0, 3) != 0);
         dmem_addr     = raddr();
         dmem_out_data = $urandom;
         dmem_rw       = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
         if ($urandom_range(0, 5) == 0) imem_addr = dmem_addr;
         if ($urandom_range(0, 499) == 0) begin
            #1 rst = 0;
            @(posedge clk);
            @(posedge clk);
            #3 rst = 1;
         end
         step();
      end

      run = 0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

endmodule
